// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared definitions for the keypad entry path: key codes, the pressed-flag
// levels, the entry FSM state encoding and aliases for the edit keys.
package keypad_entry_ctrl_pkg;

    // Non-digit key codes from the scanner; digits 0-9 map to 4'h0..4'h9
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // Edit-key roles
    localparam logic [3:0] KEY_CLEAR = KEY_A;
    localparam logic [3:0] KEY_BKSP  = KEY_B;
    localparam logic [3:0] KEY_ENTER = KEY_F;

    // Scanner pressed-flag levels
    localparam logic KEYPAD_PRESSED     = 1'b1;
    localparam logic KEYPAD_NOT_PRESSED = 1'b0;

    // Entry controller states
    typedef enum logic {
        ENTRY_EDIT = 1'b0,
        ENTRY_HOLD = 1'b1
    } entry_state_e;

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Completed-entry handshake between the keypad entry controller (master)
// and the number consumer (slave).
interface keypad_entry_ctrl_if #(
    parameter int DIGITS = 4
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                  entry_valid;
    logic [4*DIGITS-1:0]   entry_value;
    logic [CW-1:0]         entry_len;
    logic                  entry_ready;

    modport master (
        output entry_valid,
        output entry_value,
        output entry_len,
        input  entry_ready
    );

    modport slave (
        input  entry_valid,
        input  entry_value,
        input  entry_len,
        output entry_ready
    );

endinterface

// File: rtl/keypad_event_detect.sv
// Turns the scanner's pressed level into a single-cycle key event.
// ev is high for exactly one cycle per rising edge of pressed; ev_key is the
// key code sampled in that same cycle.
module keypad_event_detect
    import keypad_entry_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_key,
    input  logic       i_pressed,
    output logic       o_ev,
    output logic [3:0] o_ev_key
);

    logic r_pressed_d;

    // Delay pressed by one cycle so its rising edge can be detected
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pressed_d <= KEYPAD_NOT_PRESSED;
        end else begin
            r_pressed_d <= i_pressed;
        end
    end

    assign o_ev     = (i_pressed == KEYPAD_PRESSED) && (r_pressed_d == KEYPAD_NOT_PRESSED);
    assign o_ev_key = i_key;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: assembles digit key events into a BCD buffer,
// handles clear / backspace / enter, and offers each completed number on a
// valid/ready handshake. The live buffer also feeds the 7-segment path.
// Optional feature macro: KEYPAD_ENTRY_TIMEOUT_EN (idle timeout discarding a
// partial entry after TIMEOUT_CYCLES event-free cycles).
module keypad_entry_ctrl
    import keypad_entry_ctrl_pkg::*;
#(
    parameter  int DIGITS         = 4,
    parameter  int TIMEOUT_CYCLES = 1000,
    localparam int CW             = $clog2(DIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           key,
    input  logic                 pressed,
    output logic [4*DIGITS-1:0]  digits,
    output logic [CW-1:0]        digit_cnt,
    output logic                 err,
    output logic                 timeout,
    keypad_entry_ctrl_if.master  ent
);

    localparam int          BW       = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    // New least significant digit enters at [3:0]; the top digit falls off
    function automatic logic [BW-1:0] shift_in(input logic [BW-1:0] b, input logic [3:0] k);
        logic [BW-1:0] r;
        r      = '0;
        r[3:0] = k;
        for (int i = 1; i < DIGITS; i++) begin
            r[4*i +: 4] = b[4*(i-1) +: 4];
        end
        return r;
    endfunction

    // Drop the least significant digit; a zero digit fills the top
    function automatic logic [BW-1:0] shift_out(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            r[4*i +: 4] = b[4*(i+1) +: 4];
        end
        return r;
    endfunction

    logic          w_ev;
    logic [3:0]    w_ev_key;

    entry_state_e  r_state,   w_state_nxt;
    logic [BW-1:0] r_digits,  w_digits_nxt;
    logic [CW-1:0] r_cnt,     w_cnt_nxt;
    logic [BW-1:0] r_value,   w_value_nxt;
    logic [CW-1:0] r_len,     w_len_nxt;
    logic          r_valid,   w_valid_nxt;
    logic          r_err,     w_err_nxt;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_idle,    w_idle_nxt;
    logic          r_timeout, w_timeout_nxt;
`endif

    keypad_event_detect u_event_detect (
        .clk       (clk),
        .rst       (rst),
        .i_key     (key),
        .i_pressed (pressed),
        .o_ev      (w_ev),
        .o_ev_key  (w_ev_key)
    );

    // Next-state and buffer update for the EDIT/HOLD entry FSM
    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_cnt_nxt    = r_cnt;
        w_value_nxt  = r_value;
        w_len_nxt    = r_len;
        w_valid_nxt  = r_valid;
        w_err_nxt    = 1'b0;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        w_idle_nxt    = '0;
        w_timeout_nxt = 1'b0;
`endif

        if (r_state == ENTRY_HOLD) begin
            // Entry is frozen; any key event here is rejected
            if (w_ev) begin
                w_err_nxt = 1'b1;
            end
            if (ent.entry_ready) begin
                w_valid_nxt  = 1'b0;
                w_digits_nxt = '0;
                w_cnt_nxt    = '0;
                w_state_nxt  = ENTRY_EDIT;
            end
        end else if (w_ev) begin
            case (w_ev_key)
                KEY_CLEAR: begin
                    w_digits_nxt = '0;
                    w_cnt_nxt    = '0;
                end
                KEY_BKSP: begin
                    if (r_cnt != '0) begin
                        w_digits_nxt = shift_out(r_digits);
                        w_cnt_nxt    = r_cnt - CW'(1);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                KEY_ENTER: begin
                    if (r_cnt != '0) begin
                        w_value_nxt = r_digits;
                        w_len_nxt   = r_cnt;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ENTRY_HOLD;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                KEY_C, KEY_D, KEY_E: begin
                    // Unassigned keys are ignored without complaint
                end
                default: begin
                    // Remaining codes are the decimal digits 0-9
                    if (r_cnt != CNT_MAX) begin
                        w_digits_nxt = shift_in(r_digits, w_ev_key);
                        w_cnt_nxt    = r_cnt + CW'(1);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            endcase
        end

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        // Idle counting only while a partial entry is being edited
        if ((r_state == ENTRY_EDIT) && (r_cnt != '0) && !w_ev) begin
            if (r_idle == IDLE_LAST) begin
                w_digits_nxt  = '0;
                w_cnt_nxt     = '0;
                w_timeout_nxt = 1'b1;
            end else begin
                w_idle_nxt = r_idle + TW'(1);
            end
        end
`endif
    end

    // State and datapath registers, all returned to idle values by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ENTRY_EDIT;
            r_digits <= '0;
            r_cnt    <= '0;
            r_value  <= '0;
            r_len    <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_digits <= w_digits_nxt;
            r_cnt    <= w_cnt_nxt;
            r_value  <= w_value_nxt;
            r_len    <= w_len_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
        end
    end

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    // Idle counter and timeout pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_idle    <= w_idle_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout = 1'b0;
`endif

    assign digits          = r_digits;
    assign digit_cnt       = r_cnt;
    assign err             = r_err;
    assign ent.entry_valid = r_valid;
    assign ent.entry_value = r_value;
    assign ent.entry_len   = r_len;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: a reference model of the entry buffer
// predicts each key event, completed entries go through a scoreboard queue and
// are compared when the DUT offers them on the handshake.
module tb_keypad_entry_ctrl;
    import keypad_entry_ctrl_pkg::*;

    localparam int DIGITS = 4;
    localparam int CW     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic        pressed;
    logic [15:0] digits;
    logic [CW-1:0] digit_cnt;
    logic        err;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0]   value;
        logic [CW-1:0] len;
    } entry_t;

    entry_t      sb_q[$];
    logic        m_hold;
    logic [15:0] m_digits;
    int          m_cnt;

    always #5 clk = ~clk;

    keypad_entry_ctrl_if #(.DIGITS(DIGITS)) ent_if();

    keypad_entry_ctrl #(
        .DIGITS         (DIGITS),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .pressed   (pressed),
        .digits    (digits),
        .digit_cnt (digit_cnt),
        .err       (err),
        .timeout   (timeout),
        .ent       (ent_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold pressed for 'hold' cycles; report err in the event cycle and any err after it
    task automatic press(input logic [3:0] k, input int hold, output logic e1, output int extra);
        key     = k;
        pressed = 1'b1;
        @(negedge clk);
        e1    = err;
        extra = 0;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            extra += int'(err);
        end
        pressed = 1'b0;
        @(negedge clk);
        extra += int'(err);
    endtask

    task automatic model_reset();
        m_hold   = 1'b0;
        m_digits = 16'h0;
        m_cnt    = 0;
    endtask

    // Predict one key event with the model, drive it, and compare the result
    task automatic key_ev(input logic [3:0] k, input int hold, input string tag);
        logic exp_err;
        logic e1;
        int   extra;
        exp_err = 1'b0;
        if (m_hold) begin
            exp_err = 1'b1;
        end else if (k <= 4'h9) begin
            if (m_cnt < DIGITS) begin
                m_digits = {m_digits[11:0], k};
                m_cnt++;
            end else begin
                exp_err = 1'b1;
            end
        end else if (k == KEY_CLEAR) begin
            m_digits = 16'h0;
            m_cnt    = 0;
        end else if (k == KEY_BKSP) begin
            if (m_cnt > 0) begin
                m_digits = {4'h0, m_digits[15:4]};
                m_cnt--;
            end else begin
                exp_err = 1'b1;
            end
        end else if (k == KEY_ENTER) begin
            if (m_cnt > 0) begin
                sb_q.push_back({m_digits, CW'(m_cnt)});
                m_hold = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
        end
        press(k, hold, e1, extra);
        check({tag, ".err"},       {31'h0, e1}, {31'h0, exp_err});
        check({tag, ".err_extra"}, extra, 0);
        check({tag, ".digits"},    {16'h0, digits}, {16'h0, m_digits});
        check({tag, ".digit_cnt"}, {29'h0, digit_cnt}, m_cnt);
        check({tag, ".valid"},     {31'h0, ent_if.entry_valid}, {31'h0, m_hold});
    endtask

    // Wait for an offered entry, compare it with the scoreboard, then accept it
    task automatic accept(input string tag);
        entry_t e;
        int     n;
        n = 0;
        while (ent_if.entry_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".valid_wait"}, {31'h0, ent_if.entry_valid}, 32'h1);
        check({tag, ".sb_nonempty"}, {31'h0, (sb_q.size() > 0)}, 32'h1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, ".value"}, {16'h0, ent_if.entry_value}, {16'h0, e.value});
            check({tag, ".len"},   {29'h0, ent_if.entry_len}, {29'h0, e.len});
        end
        ent_if.entry_ready = 1'b1;
        @(negedge clk);
        ent_if.entry_ready = 1'b0;
        check({tag, ".valid_drop"}, {31'h0, ent_if.entry_valid}, 32'h0);
        check({tag, ".digits_clr"}, {16'h0, digits}, 32'h0);
        check({tag, ".cnt_clr"},    {29'h0, digit_cnt}, 32'h0);
        model_reset();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".digits"},  {16'h0, digits}, 32'h0);
        check({tag, ".cnt"},     {29'h0, digit_cnt}, 32'h0);
        check({tag, ".valid"},   {31'h0, ent_if.entry_valid}, 32'h0);
        check({tag, ".value"},   {16'h0, ent_if.entry_value}, 32'h0);
        check({tag, ".len"},     {29'h0, ent_if.entry_len}, 32'h0);
        check({tag, ".err"},     {31'h0, err}, 32'h0);
        check({tag, ".timeout"}, {31'h0, timeout}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        entry_t dropped;
        rst                = 1'b1;
        key                = 4'h0;
        pressed            = 1'b0;
        ent_if.entry_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: 1,2,3, ready ignored in EDIT, then enter and hold until accepted
        key_ev(4'h1, 1, "t1.k1");
        key_ev(4'h2, 2, "t1.k2");
        key_ev(4'h3, 1, "t1.k3");
        ent_if.entry_ready = 1'b1;
        @(negedge clk);
        ent_if.entry_ready = 1'b0;
        check("t1.ready_in_edit.digits", {16'h0, digits}, 32'h0123);
        check("t1.ready_in_edit.valid",  {31'h0, ent_if.entry_valid}, 32'h0);
        key_ev(KEY_ENTER, 1, "t1.enter");
        repeat (3) @(negedge clk);
        check("t1.hold.valid",  {31'h0, ent_if.entry_valid}, 32'h1);
        check("t1.hold.value",  {16'h0, ent_if.entry_value}, 32'h0123);
        check("t1.hold.len",    {29'h0, ent_if.entry_len}, 32'h3);
        check("t1.hold.digits", {16'h0, digits}, 32'h0123);
        accept("t1.acc");

        // 2: long press gives exactly one digit
        key_ev(4'h9, 5, "t2.k9");
        check("t2.digits", {16'h0, digits}, 32'h0009);
        key_ev(KEY_CLEAR, 1, "t2.clr");

        // 3: overflow on the fifth digit, then backspace
        for (int i = 1; i <= 5; i++) begin
            key_ev(4'(i), 1, "t3.dig");
        end
        check("t3.full", {16'h0, digits}, 32'h1234);
        key_ev(KEY_BKSP, 1, "t3.bksp");
        check("t3.bksp_digits", {16'h0, digits}, 32'h0123);

        // 4: edit keys on empty and partial buffers, unassigned keys
        key_ev(KEY_CLEAR, 1, "t4.clr_full");
        key_ev(KEY_ENTER, 1, "t4.enter_empty");
        key_ev(KEY_BKSP, 1, "t4.bksp_empty");
        key_ev(KEY_CLEAR, 1, "t4.clr_empty");
        key_ev(KEY_C, 1, "t4.keyC");
        key_ev(4'h8, 1, "t4.k8");
        key_ev(KEY_E, 3, "t4.keyE");
        key_ev(4'h4, 1, "t4.k4");
        key_ev(KEY_CLEAR, 1, "t4.clr_two");

        // 5: key in HOLD is rejected; key together with handshake is also rejected
        key_ev(4'h6, 1, "t5.k6");
        key_ev(KEY_ENTER, 1, "t5.enter");
        key_ev(4'h2, 1, "t5.hold_key");
        check("t5.sb_size", sb_q.size(), 1);
        check("t5.value", {16'h0, ent_if.entry_value}, {16'h0, sb_q[0].value});
        check("t5.len",   {29'h0, ent_if.entry_len}, {29'h0, sb_q[0].len});
        dropped = sb_q.pop_front();
        key                = 4'h7;
        pressed            = 1'b1;
        ent_if.entry_ready = 1'b1;
        @(negedge clk);
        ent_if.entry_ready = 1'b0;
        pressed            = 1'b0;
        check("t5.same.err",    {31'h0, err}, 32'h1);
        check("t5.same.valid",  {31'h0, ent_if.entry_valid}, 32'h0);
        check("t5.same.digits", {16'h0, digits}, 32'h0);
        check("t5.same.cnt",    {29'h0, digit_cnt}, 32'h0);
        @(negedge clk);
        check("t5.after.err",   {31'h0, err}, 32'h0);
        model_reset();

        // 6: idle behaviour of a partial entry
        key_ev(4'h5, 1, "t6.k5");
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j < 6) begin
                check("t6.to_early", {31'h0, timeout}, 32'h0);
            end else begin
                check("t6.to_pulse", {31'h0, timeout}, 32'h1);
                check("t6.to_cnt",   {29'h0, digit_cnt}, 32'h0);
                check("t6.to_dig",   {16'h0, digits}, 32'h0);
            end
        end
        @(negedge clk);
        check("t6.to_end", {31'h0, timeout}, 32'h0);
        model_reset();
`else
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("t6.no_timeout", {31'h0, timeout}, 32'h0);
        end
        check("t6.persist_cnt", {29'h0, digit_cnt}, 32'h1);
        check("t6.persist_dig", {16'h0, digits}, 32'h0005);
        key_ev(KEY_CLEAR, 1, "t6.clr");
`endif

        // Reset while holding an entry discards it
        key_ev(4'h4, 1, "t7.k4");
        key_ev(4'h2, 1, "t7.k2");
        key_ev(KEY_ENTER, 1, "t7.enter");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("t7.rst");
        if (sb_q.size() > 0) begin
            dropped = sb_q.pop_back();
        end
        model_reset();
        key_ev(4'h3, 1, "t7.after");
        check("t7.after_digits", {16'h0, digits}, 32'h0003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
